a2d_resp: RTL and testbench

Synthesizable SPI responder for the A2D channel link: it is the slave end of the SS_n/SCLK/MOSI/MISO interface driven by the A2D master that round-robins the slide pots. Each 16-bit frame does two things. It captures a channel command from MOSI. It returns on MISO the 12-bit value of the channel addressed in the previous frame, matching the master's command-then-read transaction pair. The block serves as the pot/ADC stand-in for FPGA bring-up and as the self-checking target for the slide interface.

---
 rtl/a2d_resp_if.sv | 10 +
 rtl/a2d_resp.sv | 137 +++++++++++++
 tb/tb_a2d_resp.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/a2d_resp_if.sv
// SPI pin bundle between the A2D master and the responder.
interface a2d_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_resp.sv
// SPI mode-0 responder for the A2D link: latches a channel command per frame
// and returns the 12-bit value of the channel addressed by the previous frame.
module a2d_resp #(
  parameter logic [2:0] RESET_CHNNL = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  a2d_resp_if.slave   spi,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [2:0]  chnnl,
  output logic        frm_done,
  output logic        frm_err
);

  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_ss, r_sclk, r_mosi;   // [0],[1] synchronisers, [2] edge-detect stage
  logic [2:0]  r_vld;
  logic [15:0] r_tx, w_tx_nxt;
  logic [15:0] r_rx, w_rx_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_done_p, w_done_nxt;
  logic        r_err_p, w_err_nxt;
  logic        r_miso;
  logic [2:0]  r_chnnl;
  logic [11:0] w_ch [8];
  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;

  assign w_ch[0] = CH0;
  assign w_ch[1] = CH1;
  assign w_ch[2] = CH2;
  assign w_ch[3] = CH3;
  assign w_ch[4] = CH4;
  assign w_ch[5] = CH5;
  assign w_ch[6] = CH6;
  assign w_ch[7] = CH7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss   <= 3'b111;
      r_sclk <= 3'b000;
      r_mosi <= 3'b000;
      r_vld  <= 3'b000;
    end else begin
      r_ss   <= {r_ss[1:0], spi.SS_n};
      r_sclk <= {r_sclk[1:0], spi.SCLK};
      r_mosi <= {r_mosi[1:0], spi.MOSI};
      r_vld  <= {r_vld[1:0], 1'b1};
    end
  end

  assign w_ss_fall   =  r_ss[2]   & ~r_ss[1];
  assign w_ss_rise   = ~r_ss[2]   &  r_ss[1];
  assign w_sclk_rise = ~r_sclk[2] &  r_sclk[1];
  assign w_sclk_fall =  r_sclk[2] & ~r_sclk[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= WAIT_HI;
      r_tx     <= 16'h0000;
      r_rx     <= 16'h0000;
      r_cnt    <= 5'd0;
      r_done_p <= 1'b0;
      r_err_p  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx     <= w_tx_nxt;
      r_rx     <= w_rx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done_p <= w_done_nxt;
      r_err_p  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      WAIT_HI: begin
        // Sync reset values look like "SS_n high"; only trust the pin once
        // it has actually propagated through the whole sync chain.
        if (r_vld[2] && r_ss[2]) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_ss_fall) begin
          w_tx_nxt    = {4'h0, w_ch[r_chnnl]};
          w_cnt_nxt   = 5'd0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_done_nxt  = (r_cnt == 5'd16);
          w_err_nxt   = (r_cnt != 5'd16);
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_rx_nxt = {r_rx[14:0], r_mosi[1]};
          if (r_cnt != 5'd17) w_cnt_nxt = r_cnt + 5'd1;
        end else if (w_sclk_fall && r_cnt != 5'd0) begin
          w_tx_nxt = {r_tx[14:0], 1'b0};
        end
      end
      default: w_state_nxt = WAIT_HI;
    endcase
  end

  // Output stage: one clk behind the internal action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso   <= 1'b0;
      frm_done <= 1'b0;
      frm_err  <= 1'b0;
      r_chnnl  <= RESET_CHNNL;
    end else begin
      r_miso   <= (r_state == SHIFT) ? r_tx[15] : 1'b0;
      frm_done <= r_done_p;
      frm_err  <= r_err_p;
      if (r_done_p) r_chnnl <= r_rx[13:11];
    end
  end

  assign spi.MISO = r_miso;
  assign chnnl    = r_chnnl;

endmodule

// File: tb/tb_a2d_resp.sv
// Directed + randomized bench for a2d_resp against a frame-level model of
// the command/read protocol.
module tb_a2d_resp;
  logic        clk;
  logic        rst_n;
  logic [11:0] ch [8];
  logic [2:0]  chnnl;
  logic        frm_done, frm_err;
  int          n_tests, n_fail;
  int          done_cnt, err_cnt;
  int          m_ch;

  a2d_resp_if intf ();

  a2d_resp #(.RESET_CHNNL(3'd0)) dut (
    .clk(clk), .rst_n(rst_n), .spi(intf.slave),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .chnnl(chnnl), .frm_done(frm_done), .frm_err(frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_done) done_cnt++;
    if (frm_err)  err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI frame as the master drives it; MISO is sampled just before each rise.
  task automatic frame(input logic [2:0] cmd, input int nrises, input int chg_at,
                       input int chg_ch, input logic [11:0] chg_val,
                       output logic [15:0] rd, output int nd, output int ne);
    logic [15:0] w;
    int d0, e0;
    w  = {2'b00, cmd, 11'h000};
    d0 = done_cnt;
    e0 = err_cnt;
    rd = 16'h0;
    intf.SS_n = 1'b0;
    intf.MOSI = w[15];
    wait_clk(10);
    for (int i = 0; i < nrises; i++) begin
      if (i == chg_at) ch[chg_ch] = chg_val;
      rd = {rd[14:0], intf.MISO};
      intf.SCLK = 1'b1;
      wait_clk(16);
      intf.SCLK = 1'b0;
      intf.MOSI = (i < 15) ? w[14-i] : 1'b0;
      wait_clk(16);
    end
    intf.SS_n = 1'b1;
    wait_clk(12);
    nd = done_cnt - d0;
    ne = err_cnt - e0;
    wait_clk(8);
  endtask

  // Runs a frame and checks it against the model: the read value is the
  // channel latched by the previous good frame, sampled at SS_n fall.
  task automatic run(input string tag, input logic [2:0] cmd, input int nrises,
                     input int chg_at, input int chg_ch, input logic [11:0] chg_val);
    logic [15:0] exp, rd;
    int nd, ne;
    exp = {4'h0, ch[m_ch]};
    frame(cmd, nrises, chg_at, chg_ch, chg_val, rd, nd, ne);
    if (nrises == 16) begin
      check({tag, ".miso"}, {16'h0, rd}, {16'h0, exp});
      m_ch = int'(cmd);
    end
    check({tag, ".done"}, nd, (nrises == 16) ? 1 : 0);
    check({tag, ".err"},  ne, (nrises == 16) ? 0 : 1);
    check({tag, ".chnnl"}, {29'h0, chnnl}, m_ch);
  endtask

  initial begin
    int seq [6];
    logic miso_seen;
    n_tests = 0; n_fail = 0; done_cnt = 0; err_cnt = 0; m_ch = 0;
    rst_n = 1'b0;
    intf.SS_n = 1'b1; intf.SCLK = 1'b0; intf.MOSI = 1'b0;
    for (int i = 0; i < 8; i++) ch[i] = 12'($urandom);
    ch[0] = 12'hABC;
    ch[3] = 12'h123;
    wait_clk(5);
    check("rst.miso",  {31'h0, intf.MISO}, 0);
    check("rst.chnnl", {29'h0, chnnl}, 0);
    check("rst.done",  {31'h0, frm_done}, 0);
    check("rst.err",   {31'h0, frm_err}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    run("basic1", 3'd3, 16, -1, 0, 12'h0);
    run("basic2", 3'd1, 16, -1, 0, 12'h0);

    seq = '{1, 0, 4, 2, 3, 7};
    for (int i = 0; i < 8; i++) ch[i] = {3'(i), 9'($urandom)};
    foreach (seq[k]) run("rrobin", 3'(seq[k]), 16, -1, 0, 12'h0);
    run("rrobin.last", 3'd5, 16, -1, 0, 12'h0);

    run("abort", 3'd6, 9, -1, 0, 12'h0);
    run("abort.next", 3'd2, 16, -1, 0, 12'h0);

    run("overrun", 3'd4, 17, -1, 0, 12'h0);
    run("overrun.next", 3'd6, 16, -1, 0, 12'h0);

    ch[m_ch] = 12'h555;
    run("midchg", 3'd1, 16, 4, m_ch, 12'hAAA);
    check("midchg.ch", {20'h0, ch[6]}, 32'hAAA);

    // Reset in the middle of a frame, released with SS_n still low.
    intf.SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 5; i++) begin
      intf.SCLK = 1'b1; wait_clk(16); intf.SCLK = 1'b0; wait_clk(16);
    end
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    m_ch = 0;
    begin
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      miso_seen = 1'b0;
      check("midrst.chnnl", {29'h0, chnnl}, 0);
      for (int i = 0; i < 8; i++) begin
        intf.MOSI = 1'($urandom);
        miso_seen |= intf.MISO;
        intf.SCLK = 1'b1; wait_clk(16);
        miso_seen |= intf.MISO;
        intf.SCLK = 1'b0; wait_clk(16);
      end
      intf.SS_n = 1'b1;
      wait_clk(20);
      check("midrst.miso", {31'h0, miso_seen}, 0);
      check("midrst.done", done_cnt - d0, 0);
      check("midrst.err",  err_cnt - e0, 0);
    end
    run("midrst.next", 3'd4, 16, -1, 0, 12'h0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) ch[i] = 12'($urandom);
      run("rand", 3'($urandom_range(0, 7)), 16, -1, 0, 12'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, required finish before 2ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
